// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, controller state encodings
// and {real,imag} word pack/unpack macros used by loader and butterfly.
`ifndef FFT_PKG_MACROS
`define FFT_PKG_MACROS
`define FFT_PACK(re, im) {re, im}
`define FFT_RE(w) w[2*DATA_W-1:DATA_W]
`define FFT_IM(w) w[DATA_W-1:0]
`endif

package fft_pkg;

    localparam int FFT_DATA_W = 16;
    localparam int FFT_N      = 16;
    localparam int FFT_LOG2N  = 4;
    localparam int FFT_TW_W   = 4;
    localparam int FFT_TMO    = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LATCH,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } fft_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Stage/group/index walker for an in-place radix-2 DIT FFT.
// Index is innermost, then group, then stage; wraps to zero after last.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int TW_W  = FFT_TW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             clear,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [TW_W-1:0]  twiddle,
    output logic             last_bfly
);

    localparam int SW = $clog2(LOG2N + 1);
    localparam logic [LOG2N-1:0] HALF = LOG2N'(N / 2);
    localparam logic [SW-1:0] LAST_ST = SW'(LOG2N - 1);

    logic [SW-1:0]    stage;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] idx;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] idx_max;
    logic [LOG2N-1:0] grp_max;
    logic [SW-1:0]    tw_sh;

    // Decode counters into RAM addresses and the twiddle index
    always_comb begin
        span      = LOG2N'(1) << stage;
        idx_max   = span - LOG2N'(1);
        grp_max   = (HALF >> stage) - LOG2N'(1);
        tw_sh     = LAST_ST - stage;
        addr_a    = ((grp << stage) << 1) + idx;
        addr_b    = addr_a + span;
        twiddle   = TW_W'(idx << tw_sh);
        last_bfly = (stage == LAST_ST) && (grp == grp_max)
                    && (idx == idx_max);
    end

    // Advance index, carry into group, then into stage
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            stage <= '0;
            grp   <= '0;
            idx   <= '0;
        end else if (step) begin
            if (idx == idx_max) begin
                idx <= '0;
                if (grp == grp_max) begin
                    grp   <= '0;
                    stage <= (stage == LAST_ST) ? '0 : stage + SW'(1);
                end else begin
                    grp <= grp + LOG2N'(1);
                end
            end else begin
                idx <= idx + LOG2N'(1);
            end
        end
    end

endmodule

// File: rtl/fft_stage_controller.sv
// Sequences all butterflies of an in-place radix-2 DIT FFT through one
// butterfly unit. Optional WAIT timeout: define FFT_CTRL_TIMEOUT_EN.
module fft_stage_controller
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N      = FFT_N,
    parameter int LOG2N  = FFT_LOG2N,
    parameter int TW_W   = FFT_TW_W,
    parameter int TMO    = FFT_TMO
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [LOG2N-1:0]    mem_addr_a,
    output logic [LOG2N-1:0]    mem_addr_b,
    input  logic [2*DATA_W-1:0] mem_rdata_a,
    input  logic [2*DATA_W-1:0] mem_rdata_b,
    output logic [2*DATA_W-1:0] mem_wdata_a,
    output logic [2*DATA_W-1:0] mem_wdata_b,
    output logic [DATA_W-1:0]   bf_ra,
    output logic [DATA_W-1:0]   bf_ca,
    output logic [DATA_W-1:0]   bf_rb,
    output logic [DATA_W-1:0]   bf_cb,
    output logic [TW_W-1:0]     bf_twiddle,
    output logic                bf_new,
    input  logic                bf_ready,
    input  logic [2*DATA_W-1:0] bf_oa,
    input  logic [2*DATA_W-1:0] bf_ob
);

    fft_state_t       state;
    logic             ready_q;
    logic             is_last;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [TW_W-1:0]  gen_tw;
    logic             gen_last;
    logic             rdy_edge;
    logic             gen_clear;

    // ready_q is forced high on arming so a level already high is ignored
    assign rdy_edge  = (state == ST_WAIT) && bf_ready && !ready_q;
    assign gen_clear = (state == ST_IDLE);

`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] tmo_cnt;
    logic          err_r;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    fft_addr_gen #(
        .N     (N),
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .step      (rdy_edge),
        .clear     (gen_clear),
        .addr_a    (gen_a),
        .addr_b    (gen_b),
        .twiddle   (gen_tw),
        .last_bfly (gen_last)
    );

    // Main sequencer: read, latch operands, await result, write back
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr_a  <= '0;
            mem_addr_b  <= '0;
            mem_wdata_a <= '0;
            mem_wdata_b <= '0;
            bf_ra       <= '0;
            bf_ca       <= '0;
            bf_rb       <= '0;
            bf_cb       <= '0;
            bf_twiddle  <= '0;
            bf_new      <= 1'b0;
            ready_q     <= 1'b0;
            is_last     <= 1'b0;
`ifdef FFT_CTRL_TIMEOUT_EN
            tmo_cnt     <= '0;
            err_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RD;
                        busy       <= 1'b1;
                        mem_rd_en  <= 1'b1;
                        mem_addr_a <= gen_a;
                        mem_addr_b <= gen_b;
`ifdef FFT_CTRL_TIMEOUT_EN
                        err_r      <= 1'b0;
`endif
                    end
                end
                ST_RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= ST_LATCH;
                end
                ST_LATCH: begin
                    bf_ra      <= `FFT_RE(mem_rdata_a);
                    bf_ca      <= `FFT_IM(mem_rdata_a);
                    bf_rb      <= `FFT_RE(mem_rdata_b);
                    bf_cb      <= `FFT_IM(mem_rdata_b);
                    bf_twiddle <= gen_tw;
                    bf_new     <= ~bf_new;
                    ready_q    <= 1'b1;
                    state      <= ST_WAIT;
`ifdef FFT_CTRL_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                end
                ST_WAIT: begin
                    ready_q <= bf_ready;
                    if (rdy_edge) begin
                        mem_wr_en   <= 1'b1;
                        mem_wdata_a <= bf_oa;
                        mem_wdata_b <= bf_ob;
                        is_last     <= gen_last;
                        state       <= ST_WR;
                    end
`ifdef FFT_CTRL_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TMO - 1)) begin
                        err_r <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
`endif
                end
                ST_WR: begin
                    mem_wr_en <= 1'b0;
                    if (is_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state      <= ST_RD;
                        mem_rd_en  <= 1'b1;
                        mem_addr_a <= gen_a;
                        mem_addr_b <= gen_b;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
